// File: rtl/conway_pkg.sv
// ============================================================================
// Module : conway_pkg
// Brief  : Shared grid geometry constants and fetch FSM state type for the
//          Conway accelerator, pixel fetch stage and VGA controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package conway_pkg;

  localparam int WORD_W        = 20;    // cells per memory word
  localparam int WORDS_PER_ROW = 64;    // words per grid row
  localparam int ROWS          = 1024;  // grid rows
  localparam int ADDR_W        = 16;    // log2(ROWS*WORDS_PER_ROW)

  localparam int WIDX_W = $clog2(WORDS_PER_ROW);          // word index in a row
  localparam int ROW_W  = ADDR_W - WIDX_W;                // row index
  localparam int BIT_W  = $clog2(WORD_W);                 // bit index in a word
  localparam int PIX_W  = $clog2(WORD_W * WORDS_PER_ROW); // pixel index in a row
  localparam int SLOT_W = WIDX_W + 1;                     // word slot incl. one past end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/word_fifo.sv
// ============================================================================
// Module : word_fifo
// Brief  : Synchronous first-word-fall-through FIFO with flush and occupancy
//          count. Push and pop in the same cycle are both honoured.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module word_fifo
  import conway_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WORD_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  // A full FIFO can still take a word if one leaves in the same cycle.
  assign w_do_push = i_push & (~w_full | w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy; flush empties the buffer immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/conway_pixel_fetch.sv
// ============================================================================
// Module : conway_pixel_fetch
// Brief  : Prefetches one grid row per visible line from the memory B port,
//          buffers words in a small FIFO and serialises them one cell per
//          pixel request. Flags underruns and pulses frame_done after the
//          last pixel of the last row.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module conway_pixel_fetch
  import conway_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              line_start,
  input  logic [ROW_W-1:0]  line_row,
  input  logic              pixel_req,
  output logic              pixel_alive,
  output logic              pixel_valid,
  output logic              line_busy,
  output logic              frame_done,
  output logic              underrun,
  input  logic              clear_underrun,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  input  logic              mem_wait,
  input  logic [WORD_W-1:0] mem_q
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(WORDS_PER_ROW - 1);
  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(WORD_W * WORDS_PER_ROW - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_W - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

  fetch_state_t      r_state;
  logic [ROW_W-1:0]  r_row;
  logic [WIDX_W-1:0] r_word_idx;
  logic [RD_LATENCY-1:0] r_pipe;
  logic [WORD_W-1:0] r_word;
  logic              r_loaded;
  logic [BIT_W-1:0]  r_bit;
  logic [SLOT_W-1:0] r_slot;
  logic [SLOT_W-1:0] r_pop_idx;
  logic [PIX_W-1:0]  r_pix;
  logic              r_alive;
  logic              r_valid;
  logic              r_frame_done;
  logic              r_underrun;

  logic              w_active;
  logic              w_accept;
  logic              w_px;
  logic              w_bit_last;
  logic              w_line_end;
  logic              w_fill;
  logic              w_roll;
  logic              w_pop;
  logic              w_push;
  logic [SLOT_W-1:0] w_slot_next;
  logic [BIT_W-1:0]  w_bit_sel;
  logic [7:0]        w_inflight;
  logic [7:0]        w_used;
  logic [WORD_W-1:0] w_fifo_q;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_fifo_empty;

  assign w_active   = (r_state != IDLE);
  assign w_accept   = mem_read & ~mem_wait;
  // A request on a line_start cycle is dropped in favour of the new line.
  assign w_px       = pixel_req & w_active & ~line_start;
  assign w_bit_last = (r_bit == LAST_BIT);
  assign w_line_end = w_px & (r_pix == LAST_PIX);
  assign w_bit_sel  = LAST_BIT - r_bit;

  // Word slot of the pixel after this cycle; a FIFO word is loaded only if it
  // belongs to that slot, older words were missed by underrun and are dropped.
  assign w_slot_next = (w_px && w_bit_last) ? r_slot + SLOT_W'(1) : r_slot;
  assign w_fill      = w_active & ~r_loaded & ~w_fifo_empty;
  assign w_roll      = w_px & r_loaded & w_bit_last;
  assign w_pop       = ~line_start & (w_fill | (w_roll & ~w_fifo_empty));
  assign w_push      = r_pipe[RD_LATENCY-1] & ~line_start;

  // Outstanding reads: number of valid slots in the latency pipe.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_inflight = w_inflight + 8'(r_pipe[i]);
    end
  end

  // Credit rule: buffered plus outstanding words never exceed the FIFO depth.
  assign w_used      = 8'(w_fifo_count) + w_inflight;
  assign mem_read    = (r_state == FETCH) && (w_used < 8'(FIFO_DEPTH));
  assign mem_address = {r_row, r_word_idx};

  assign line_busy   = w_active;
  assign pixel_alive = r_alive;
  assign pixel_valid = r_valid;
  assign frame_done  = r_frame_done;
  assign underrun    = r_underrun;

  word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_word_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_flush (line_start),
    .i_push  (w_push),
    .i_data  (mem_q),
    .i_pop   (w_pop),
    .o_data  (w_fifo_q),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty)
  );

  // Line FSM, latched row and read word index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_row      <= '0;
      r_word_idx <= '0;
    end else if (line_start) begin
      r_state    <= FETCH;
      r_row      <= line_row;
      r_word_idx <= '0;
    end else begin
      if (w_accept) r_word_idx <= r_word_idx + WIDX_W'(1);
      if (w_line_end) begin
        r_state <= IDLE;
      end else if (r_state == FETCH && w_accept && r_word_idx == LAST_WORD) begin
        r_state <= DRAIN;
      end
    end
  end

  // Read latency valid pipe; cleared on a new line so stale returns vanish.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pipe <= '0;
    end else if (line_start) begin
      r_pipe <= '0;
    end else begin
      r_pipe <= RD_LATENCY'({r_pipe, w_accept});
    end
  end

  // Serialiser and pixel geometry counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word    <= '0;
      r_loaded  <= 1'b0;
      r_bit     <= '0;
      r_slot    <= '0;
      r_pop_idx <= '0;
      r_pix     <= '0;
    end else if (line_start) begin
      r_loaded  <= 1'b0;
      r_bit     <= '0;
      r_slot    <= '0;
      r_pop_idx <= '0;
      r_pix     <= '0;
    end else begin
      if (w_px) begin
        r_pix  <= w_line_end ? '0 : r_pix + PIX_W'(1);
        r_bit  <= w_bit_last ? '0 : r_bit + BIT_W'(1);
        r_slot <= w_slot_next;
      end
      if (w_pop) r_pop_idx <= r_pop_idx + SLOT_W'(1);
      if (w_roll) begin
        r_word   <= w_fifo_q;
        r_loaded <= ~w_fifo_empty;
      end else if (w_fill && r_pop_idx == w_slot_next) begin
        r_word   <= w_fifo_q;
        r_loaded <= 1'b1;
      end
      if (w_line_end) r_loaded <= 1'b0;
    end
  end

  // Registered pixel output, frame pulse and sticky underrun flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alive      <= 1'b0;
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_valid      <= w_px & r_loaded;
      r_alive      <= w_px & r_loaded & r_word[w_bit_sel];
      r_frame_done <= w_line_end & (r_row == LAST_ROW);
      if (w_px && !r_loaded) r_underrun <= 1'b1;
      else if (clear_underrun) r_underrun <= 1'b0;
    end
  end

endmodule

`default_nettype wire
